// File: rtl/dilithium_pkg.sv
// Shared Dilithium constants and the rejection-sampler state encoding.
// Also holds the helper that builds a 23-bit candidate from three stream bytes.
package dilithium_pkg;

  localparam int DIL_Q       = 8380417;
  localparam int DIL_N       = 256;
  localparam int DIL_COEFF_W = 23;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } samp_state_e;

  // The top bit of the third byte is dropped so candidates span 0..2^23-1.
  function automatic logic [22:0] cand_from_bytes(input logic [7:0] b0,
                                                  input logic [7:0] b1,
                                                  input logic [7:0] b2);
    return {b2[6:0], b1, b0};
  endfunction

endpackage

// File: rtl/rej_ntt_sampler.sv
// Rejection sampler: turns squeezed sponge words into N coefficients below Q.
// A 6-byte buffer feeds one 3-byte candidate per cycle into a single output register.
module rej_ntt_sampler
  import dilithium_pkg::*;
#(
  parameter int DATA_IN_BITS = 32,
  parameter int Q            = DIL_Q,
  parameter int N            = DIL_N,
  parameter int COEFF_W      = DIL_COEFF_W,
  localparam int IDX_W       = $clog2(N)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DATA_IN_BITS-1:0] data_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [COEFF_W-1:0]      coeff_out,
  output logic [IDX_W-1:0]        coeff_idx,
  output logic                    coeff_valid,
  input  logic                    coeff_ready,
  output logic                    busy,
  output logic                    done,
  output samp_state_e             state_dbg,
  output logic [2:0]              buf_cnt_dbg
);

  // Handshakes: a word moves when in_valid && in_ready at a rising edge; a
  // coefficient moves when coeff_valid && coeff_ready. Valid never drops and
  // data never changes while waiting for ready.

  localparam int BUF_BYTES  = 6;
  localparam int WORD_BYTES = DATA_IN_BITS / 8;
  localparam int CNT_W      = IDX_W + 1;
  localparam logic [31:0] Q_U = 32'(Q);

  samp_state_e        state_q;
  logic [7:0]         buf_q [BUF_BYTES];
  logic [7:0]         buf_d [BUF_BYTES];
  logic [2:0]         buf_cnt_q, buf_cnt_d;
  logic [CNT_W-1:0]   acc_cnt_q;
  logic [COEFF_W-1:0] coeff_out_q;
  logic [IDX_W-1:0]   coeff_idx_q;
  logic               coeff_valid_q;
  logic               busy_q;
  logic               done_q;

  logic        push, pop, accept, flush;
  logic        cand_exists, cand_reject, out_free, last_coeff;
  logic [22:0] cand;

  assign in_ready    = (state_q == ST_RUN) && (buf_cnt_q <= 3'd2);
  assign push        = in_valid && in_ready;
  assign cand_exists = (state_q == ST_RUN) && (buf_cnt_q >= 3'd3);
  assign cand        = cand_from_bytes(buf_q[0], buf_q[1], buf_q[2]);
  assign cand_reject = {9'd0, cand} >= Q_U;
  assign out_free    = !coeff_valid_q || coeff_ready;
  assign pop         = cand_exists && (cand_reject || out_free);
  assign accept      = pop && !cand_reject;
  assign last_coeff  = (acc_cnt_q == CNT_W'(N - 1));
  // Buffer is emptied both when a polynomial begins and when it finishes.
  assign flush       = ((state_q == ST_IDLE) && start) ||
                       ((state_q == ST_DRAIN) && coeff_valid_q && coeff_ready);

  always_comb begin
    int unsigned wr_idx;
    for (int i = 0; i < BUF_BYTES; i++) buf_d[i] = buf_q[i];
    buf_cnt_d = buf_cnt_q;
    wr_idx    = 0;
    if (pop) begin
      for (int i = 0; i < BUF_BYTES - 3; i++) buf_d[i] = buf_q[i + 3];
      for (int i = BUF_BYTES - 3; i < BUF_BYTES; i++) buf_d[i] = 8'h00;
      buf_cnt_d = buf_cnt_q - 3'd3;
    end
    if (push) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        wr_idx = 32'(buf_cnt_d) + 32'(b);
        if (wr_idx < BUF_BYTES) buf_d[wr_idx] = data_in[8*b +: 8];
      end
      buf_cnt_d = buf_cnt_d + 3'(WORD_BYTES);
    end
    if (flush) begin
      for (int i = 0; i < BUF_BYTES; i++) buf_d[i] = 8'h00;
      buf_cnt_d = 3'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      for (int i = 0; i < BUF_BYTES; i++) buf_q[i] <= 8'h00;
      buf_cnt_q     <= 3'd0;
      acc_cnt_q     <= '0;
      coeff_out_q   <= '0;
      coeff_idx_q   <= '0;
      coeff_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      for (int i = 0; i < BUF_BYTES; i++) buf_q[i] <= buf_d[i];
      buf_cnt_q <= buf_cnt_d;
      done_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q   <= ST_RUN;
            acc_cnt_q <= '0;
            busy_q    <= 1'b1;
          end
        end
        ST_RUN: begin
          if (accept) begin
            coeff_out_q   <= COEFF_W'(cand);
            coeff_idx_q   <= acc_cnt_q[IDX_W-1:0];
            coeff_valid_q <= 1'b1;
            acc_cnt_q     <= acc_cnt_q + 1'b1;
            if (last_coeff) state_q <= ST_DRAIN;
          end else if (coeff_ready) begin
            coeff_valid_q <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (coeff_valid_q && coeff_ready) begin
            coeff_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b1;
            state_q       <= ST_DONE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign coeff_out   = coeff_out_q;
  assign coeff_idx   = coeff_idx_q;
  assign coeff_valid = coeff_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign state_dbg   = state_q;
  assign buf_cnt_dbg = buf_cnt_q;

endmodule

// File: doc/rej_ntt_sampler.md
REJ_NTT_SAMPLER -- requirements
Module: rej_ntt_sampler

Interface
REQ-001 SHALL have parameter DATA_IN_BITS, default 32; width of squeezed words consumed from the sponge output.
REQ-002 SHALL have parameter Q, default 8380417; Dilithium modulus, acceptance bound.
REQ-003 SHALL have parameter N, default 256; coefficients produced per polynomial.
REQ-004 SHALL have parameter COEFF_W, default 23; coefficient width.
REQ-005 SHALL have port clk, input, 1; the single clock; one clock, all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1; reset, asynchronous and active-high.
REQ-007 SHALL have port start, input, 1; one-cycle pulse that begins sampling one polynomial.
REQ-008 SHALL have port data_in, input, DATA_IN_BITS; squeezed word, byte 0 in bits [7:0].
REQ-009 SHALL have port in_valid, input, 1; data_in valid (driven from sponge out_valid).
REQ-010 SHALL have port in_ready, output, 1; sampler accepts data_in this cycle (drives sponge out_ready).
REQ-011 SHALL have port coeff_out, output, COEFF_W; accepted coefficient.
REQ-012 SHALL have port coeff_idx, output, $clog2(N); index 0..N-1 of coeff_out.
REQ-013 SHALL have port coeff_valid, output, 1; coeff_out/coeff_idx valid.
REQ-014 SHALL have port coeff_ready, input, 1; downstream accepts coefficient.
REQ-015 SHALL have port busy, output, 1; high in RUN and DRAIN.
REQ-016 SHALL have port done, output, 1; one-cycle pulse after the N-th coefficient handshake.

Function
REQ-017 SHALL implement states IDLE, RUN, DRAIN, DONE; IDLE->RUN on start; RUN->DRAIN when the N-th coefficient is loaded into the output register; DRAIN->DONE on that coefficient's handshake; DONE->IDLE unconditionally after one cycle.
REQ-018 SHALL ignore start outside IDLE.
REQ-019 SHALL hold a byte buffer of 6 bytes with count buf_cnt 0..6; in_ready = (state==RUN) && (buf_cnt <= 2), registered-free combinational from state only.
REQ-020 SHALL append the 4 bytes of data_in above existing buffered bytes on in_valid && in_ready, byte 0 first.
REQ-021 SHALL form a candidate in RUN when buf_cnt >= 3: b0 | b1<<8 | (b2 & 0x7F)<<16 (top bit of byte 2 discarded).
REQ-022 SHALL pop the 3 candidate bytes in a cycle when candidate exists and either candidate >= Q (reject, no output) or output register is free (!coeff_valid || coeff_ready); accepted candidate (< Q) loads coeff_out, coeff_idx = accepted count, coeff_valid=1 next cycle.
REQ-023 SHALL allow push and pop in the same cycle; buf_cnt next = buf_cnt + 4*push - 3*pop.
REQ-024 SHALL hold coeff_out/coeff_idx/coeff_valid stable while coeff_valid && !coeff_ready.
REQ-025 SHALL stop popping and deassert in_ready once N coefficients accepted; leftover buffered bytes discarded on entering DONE.
REQ-026 Latency: word accepted at cycle t -> its first candidate evaluated t+1 -> coeff_valid at t+2 if accepted and output free.
REQ-027 SHALL assert done only in DONE, exactly one cycle; coeff_valid low in DONE and IDLE.
REQ-028 SHALL process one candidate per cycle at most; sustained throughput bounded by 4 bytes per accepted word.

Reset
REQ-029 SHALL on rst: state=IDLE, buf_cnt=0, buffer=0, accepted count=0, coeff_out=0, coeff_idx=0, coeff_valid=0, in_ready=0, busy=0, done=0.
REQ-030 Reset mid-operation SHALL abandon the polynomial; no done pulse; next start begins at index 0.

Structure
REQ-031 Q, N, COEFF_W and state encoding SHALL live in shared package dilithium_pkg.
REQ-032 No sub-module; buffer, comparator and FSM in one module.

Verification
REQ-033 start; words 0x00000001, 0x00000000 -> coeffs 1 (idx0), 0 (idx1); bytes 00 00 remain buffered, buf_cnt=2.
REQ-034 Candidate bytes 00 E0 7F (8380416) accepted; 01 E0 7F (8380417) rejected, no coeff_valid; FF FF FF rejected.
REQ-035 Candidate bytes 05 00 80 -> coeff 5 (top bit masked).
REQ-036 coeff_ready held low 10 cycles with valid coeff -> outputs stable, buffer fills to <=6, in_ready falls, no data lost.
REQ-037 Stream of 0x00000000 words -> exactly 256 coeffs idx 0..255, one done pulse, in_ready low after, busy low in IDLE.
REQ-038 rst asserted at coefficient 100 -> all outputs reset immediately; new start restarts at idx 0.
